if_stage: RTL

Instruction fetch stage for the 5-stage MIPS pipeline. It sits upstream of ID and owns the PC. It issues word requests to instruction memory over a req/ack handshake and delivers fetched instructions, with their PC and PC+4, to ID. It honours the redirect (`Alt_PC`/`Request_Alt_PC`) and `WANT_FREEZE` outputs that ID drives back.

---
 rtl/if_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack
// handshake and hands instructions (with PC and PC+4) to ID. Honours ID's
// redirect and freeze, with a one-entry skid buffer for a response that
// lands while ID is frozen.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h00400000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Alt_PC_IN,
    input  logic        Request_Alt_PC_IN,
    input  logic        WANT_FREEZE_IN,
    output logic        IMem_Req_OUT,
    output logic [31:0] IMem_Addr_OUT,
    input  logic        IMem_Ack_IN,
    input  logic [31:0] IMem_Data_IN,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4_OUT,
    output logic        Instr_Valid_OUT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // one cycle after reset before the first request
        S_WAIT = 2'd1,  // request outstanding on IMem
        S_FULL = 2'd2   // response held in the skid buffer while ID is frozen
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic [31:0] alt_w;
    logic        redir;
    logic        frz;
    logic        squash;

    // Redirect targets are word aligned; the low bits are simply dropped.
    assign alt_w  = Alt_PC_IN & ~32'h3;
    assign redir  = Request_Alt_PC_IN;
    assign frz    = WANT_FREEZE_IN;
    // A response in flight when a redirect is seen (now or earlier) is the
    // post-delay-slot fetch and must never reach ID.
    assign squash = pend_q | redir;

    assign IMem_Req_OUT       = (state_q == S_WAIT);
    assign IMem_Addr_OUT      = addr_q;
    assign Instr1_OUT         = instr_q;
    assign Instr_PC_OUT       = pc_q;
    assign Instr_PC_Plus4_OUT = pc4_q;
    assign Instr_Valid_OUT    = valid_q;

    // Next-state and next-output logic; priority is redirect > freeze > normal.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pend_d      = pend_q;
        pend_tgt_d  = pend_tgt_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_WAIT;
                if (redir) addr_d = alt_w;
            end

            S_WAIT: begin
                if (!IMem_Ack_IN) begin
                    // Address held; remember the latest redirect for the ack.
                    if (redir) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = alt_w;
                    end
                    if (!frz) begin
                        instr_d = 32'h0;
                        valid_d = 1'b0;
                    end
                end else if (squash) begin
                    // Drop the data and refetch at the target back-to-back,
                    // even under freeze.
                    addr_d = redir ? alt_w : pend_tgt_q;
                    pend_d = 1'b0;
                    if (!frz) begin
                        instr_d = 32'h0;
                        valid_d = 1'b0;
                    end
                end else if (!frz) begin
                    instr_d = IMem_Data_IN;
                    pc_d    = addr_q;
                    pc4_d   = addr_q + 32'd4;
                    valid_d = 1'b1;
                    addr_d  = addr_q + 32'd4;
                end else begin
                    buf_instr_d = IMem_Data_IN;
                    buf_pc_d    = addr_q;
                    state_d     = S_FULL;
                end
            end

            S_FULL: begin
                if (redir) begin
                    state_d = S_WAIT;
                    addr_d  = alt_w;
                    if (!frz) begin
                        instr_d = 32'h0;
                        valid_d = 1'b0;
                    end
                end else if (!frz) begin
                    instr_d = buf_instr_q;
                    pc_d    = buf_pc_q;
                    pc4_d   = buf_pc_q + 32'd4;
                    valid_d = 1'b1;
                    addr_d  = buf_pc_q + 32'd4;
                    state_d = S_WAIT;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            addr_q      <= RESET_PC;
            pend_q      <= 1'b0;
            pend_tgt_q  <= 32'h0;
            buf_instr_q <= 32'h0;
            buf_pc_q    <= 32'h0;
            instr_q     <= 32'h0;
            pc_q        <= 32'h0;
            pc4_q       <= 32'h0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            pend_tgt_q  <= pend_tgt_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
        end
    end

endmodule
